// File: rtl/core_pkg.sv
// Shared constants and FSM state type for the RV32I register file.
package core_pkg;

  localparam int          XLEN      = 32;
  localparam int          NREGS     = 32;
  localparam logic [31:0] MEM_DEPTH = 32'h0010_0000;
  localparam logic [31:0] SP_INIT   = 32'h0100_0000 + MEM_DEPTH;

  typedef enum logic [0:0] {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_read_port.sv
// One read port: forces x0 and not-ready reads to zero, optionally forwards a same-cycle write.
module rf_read_port
  import core_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0]   addr,
  input  logic            ready,
  input  logic            write_enable,
  input  logic [AW-1:0]   addr_rd,
  input  logic [XLEN-1:0] data_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic [XLEN-1:0] data
);

  // Read data selection: zero, forwarded write data, or stored entry
  always_comb begin
    data = '0;
    if (!ready || (addr == '0)) begin
      data = '0;
    end else if ((BYPASS != 0) && write_enable && (addr_rd == addr)) begin
      data = data_rd;
    end else begin
      data = mem_data;
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with a reset-driven init sequencer that writes one entry per clock.
module register_file_mp
  import core_pkg::*;
#(
  parameter int              XLEN    = core_pkg::XLEN,
  parameter int              NREGS   = core_pkg::NREGS,
  parameter int              NUM_RD  = 2,
  parameter int              BYPASS  = 1,
  parameter int              SP_IDX  = 2,
  parameter logic [XLEN-1:0] SP_INIT = core_pkg::SP_INIT
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [NUM_RD*$clog2(NREGS)-1:0]  addr_rs,
  output logic [NUM_RD*XLEN-1:0]           data_rs,
  input  logic [$clog2(NREGS)-1:0]         addr_rd,
  input  logic [XLEN-1:0]                  data_rd,
  input  logic                             write_enable,
  output logic                             ready
);

  localparam int AW = $clog2(NREGS);

  rf_state_e       state;
  logic [AW-1:0]   init_idx;
  logic            init_last;
  logic [XLEN-1:0] init_val;
  logic [XLEN-1:0] mem [NREGS];

  assign init_last = (init_idx == AW'(NREGS - 1));
  assign init_val  = (init_idx == AW'(SP_IDX)) ? SP_INIT : '0;

  // Init sequencer: walks every entry once after reset, then holds in RUN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RF_INIT;
      init_idx <= '0;
      ready    <= 1'b0;
    end else begin
      case (state)
        RF_INIT: begin
          init_idx <= init_idx + AW'(1);
          if (init_last) begin
            state <= RF_RUN;
            ready <= 1'b1;
          end
        end
        RF_RUN: begin
          state <= RF_RUN;
          ready <= 1'b1;
        end
        default: begin
          state    <= RF_INIT;
          init_idx <= '0;
          ready    <= 1'b0;
        end
      endcase
    end
  end

  // Single write port, no reset, so the array can map onto RAM primitives
  always_ff @(posedge clock) begin
    if (state == RF_INIT) begin
      mem[init_idx] <= init_val;
    end else if (write_enable && (addr_rd != '0)) begin
      mem[addr_rd] <= data_rd;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]   addr_k;
    logic [XLEN-1:0] mem_k;

    assign addr_k = addr_rs[k*AW +: AW];
    assign mem_k  = mem[addr_k];

    rf_read_port #(
      .XLEN   (XLEN),
      .AW     (AW),
      .BYPASS (BYPASS)
    ) u_port (
      .addr         (addr_k),
      .ready        (ready),
      .write_enable (write_enable),
      .addr_rd      (addr_rd),
      .data_rd      (data_rd),
      .mem_data     (mem_k),
      .data         (data_rs[k*XLEN +: XLEN])
    );
  end

endmodule
